posit_mult_checker: RTL and testbench
=====================================

POSIT_MULT_CHECKER -- requirements
Module: posit_mult_checker

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter ES, default 2, exponent size; used only for NaR/zero encodings.
REQ-003 SHALL have parameter LATENCY, default 4, multiplier latency in cycles; legal range 1..16.
REQ-004 SHALL have parameter TOL, default 0, maximum |expected - result| counted as a pass.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, high in a cycle = one vector issued to the multiplier that cycle.
REQ-008 SHALL have port exp_in, input, N, expected posit product for the vector issued this cycle.
REQ-009 SHALL have ports dut_result (N), dut_inf (1), dut_zero (1), dut_done (1), all inputs, the multiplier outputs.
REQ-010 SHALL have port diff, output, N, unsigned |expected - dut_result| of the checked vector.
REQ-011 SHALL have port diff_valid, output, 1, one-cycle strobe qualifying diff and mismatch.
REQ-012 SHALL have port mismatch, output, 1, checked vector failed.
REQ-013 SHALL have ports vec_count, err_count, proto_count, outputs, 32 each: checked vectors, failed vectors, done-protocol errors.
REQ-014 SHALL have port max_diff, output, N, largest diff seen in the run.
REQ-015 SHALL have ports busy (1) and report_valid (1), outputs; report_valid is a one-cycle end-of-run strobe.

Function
REQ-016 SHALL keep a LATENCY-deep shift line of {valid, expected}, shifting every cycle; valid = start, expected = exp_in.
REQ-017 SHALL check, on a cycle where the line tap is valid, the tap expected against dut_result sampled that same cycle (vector issued at cycle t checked at t+LATENCY).
REQ-018 SHALL register check outputs: diff/diff_valid/mismatch appear the cycle after the check cycle.
REQ-019 SHALL compute diff as unsigned N-bit magnitude difference with no wrap: larger operand minus smaller.
REQ-020 SHALL set mismatch when diff > TOL, or expected = NaR (1 followed by N-1 zeros) and dut_inf = 0, or expected = 0 and dut_zero = 0.
REQ-021 SHALL increment proto_count when the tap is valid and dut_done = 0; the diff check still runs.
REQ-022 SHALL increment vec_count per check and err_count per mismatch, both saturating at 0xFFFFFFFF.
REQ-023 SHALL update max_diff = max(max_diff, diff) per check.
REQ-024 SHALL implement states IDLE, RUN, DRAIN, REPORT.
REQ-025 SHALL transition IDLE->RUN on start = 1, clearing all counters and max_diff in that cycle; the start-cycle vector is captured.
REQ-026 SHALL transition RUN->DRAIN on start = 0, with a drain counter loaded to LATENCY+1.
REQ-027 SHALL transition DRAIN->RUN on start = 1 without clearing counters; the line keeps all in-flight entries.
REQ-028 SHALL transition DRAIN->REPORT when the drain counter reaches 0 and the line holds no valid entry.
REQ-029 SHALL assert report_valid for exactly one cycle in REPORT, then go REPORT->IDLE.
REQ-030 SHALL hold counters and max_diff stable in IDLE and REPORT.
REQ-031 SHALL drive busy = 1 in RUN and DRAIN, 0 otherwise.
REQ-032 SHALL ignore start in REPORT; a start in that cycle does not begin a run.

Reset
REQ-033 SHALL, on reset, clear all shift-line valid bits, enter IDLE, and drive all outputs to 0.
REQ-034 SHALL let reset override every other event; reset mid-run discards in-flight vectors with no report_valid.

Verification
REQ-035 SHALL cover: start high 1 cycle, exp_in = 0x40000000, dut_result = 0x40000000 and dut_done = 1 at +4 -> diff_valid at +5, diff = 0, mismatch = 0; report_valid follows, vec_count = 1, err_count = 0.
REQ-036 SHALL cover: exp_in = 0x40000000, dut_result = 0x40000003 at +4 with TOL = 0 -> diff = 3, mismatch = 1, err_count = 1, max_diff = 3; rerun with TOL = 3 -> mismatch = 0.
REQ-037 SHALL cover: exp_in = 0x80000000, dut_result = 0x80000000, dut_inf = 0 -> mismatch = 1 although diff = 0.
REQ-038 SHALL cover: 100 back-to-back vectors, then start low 2 cycles, then 50 more -> single run, vec_count = 150, one report_valid.
REQ-039 SHALL cover: dut_done = 0 on 3 checked cycles -> proto_count = 3; reset asserted at run cycle 10 -> IDLE, all outputs 0, no report_valid.

Source files
------------

// File: rtl/posit_mult_checker_if.sv
// Bus between a posit multiplier under test and its result checker.
// The master side drives one vector per start cycle plus the multiplier
// outputs; the slave side (the checker) returns the check results and run statistics.
interface posit_mult_checker_if #(
   parameter int N = 32
);
   logic          start;
   logic [N-1:0]  exp_in;
   logic [N-1:0]  dut_result;
   logic          dut_inf;
   logic          dut_zero;
   logic          dut_done;

   logic [N-1:0]  diff;
   logic          diff_valid;
   logic          mismatch;
   logic [31:0]   vec_count;
   logic [31:0]   err_count;
   logic [31:0]   proto_count;
   logic [N-1:0]  max_diff;
   logic          busy;
   logic          report_valid;

   modport master (
      output start, exp_in, dut_result, dut_inf, dut_zero, dut_done,
      input  diff, diff_valid, mismatch, vec_count, err_count, proto_count,
             max_diff, busy, report_valid
   );

   modport slave (
      input  start, exp_in, dut_result, dut_inf, dut_zero, dut_done,
      output diff, diff_valid, mismatch, vec_count, err_count, proto_count,
             max_diff, busy, report_valid
   );
endinterface

// File: rtl/posit_mult_checker.sv
// Posit multiplier result checker: delays each issued expected product by the
// multiplier latency, compares it against the multiplier output, and keeps
// per-run error statistics with an end-of-run report strobe.
module posit_mult_checker #(
   parameter int N       = 32,
   parameter int ES      = 2,
   parameter int LATENCY = 4,
   parameter int TOL     = 0
) (
   input  logic                clk,
   input  logic                reset,
   posit_mult_checker_if.slave bus
);

   if (LATENCY < 1 || LATENCY > 16 || ES < 0 || ES > N - 3) begin : g_param_check
      $error("posit_mult_checker: LATENCY must be 1..16 and ES must fit the word");
   end

   // NaR is a sign bit followed by zeros; zero is all zeros, independent of ES.
   localparam logic [N-1:0] NAR        = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] TOL_V      = N'(TOL);
   localparam logic [4:0]   DRAIN_LOAD = 5'(LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

   state_t             state_q, state_d;
   logic [4:0]         drain_cnt;
   logic [LATENCY-1:0] vld_line;
   logic [N-1:0]       exp_line [LATENCY];
   logic               capture;
   logic               run_clear;

   logic               tap_vld_p0;
   logic [N-1:0]       tap_exp_p0;
   logic [N-1:0]       diff_p0;
   logic               mism_p0;

   logic               vld_p1;
   logic [N-1:0]       diff_p1;
   logic               mism_p1;
   logic [31:0]        vec_cnt_q, err_cnt_q, proto_cnt_q;
   logic [N-1:0]       max_diff_q;

   function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A start during the report cycle is ignored, so it must not enter the line either.
   assign capture = bus.start && (state_q != S_REPORT);

   // Valid bits of the delay line: control, cleared on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_line <= '0;
      end else begin
         vld_line[0] <= capture;
         for (int i = 1; i < LATENCY; i++) begin
            vld_line[i] <= vld_line[i-1];
         end
      end
   end

   // Expected-value payload of the delay line: pure data, qualified by vld_line.
   always_ff @(posedge clk) begin
      exp_line[0] <= bus.exp_in;
      for (int i = 1; i < LATENCY; i++) begin
         exp_line[i] <= exp_line[i-1];
      end
   end

   // ---- stage p0: line tap compared against the multiplier output of this cycle ----
   assign tap_vld_p0 = vld_line[LATENCY-1];
   assign tap_exp_p0 = exp_line[LATENCY-1];

   // Magnitude difference and pass/fail decision for the vector at the tap.
   always_comb begin
      diff_p0 = abs_diff(tap_exp_p0, bus.dut_result);
      mism_p0 = (diff_p0 > TOL_V)
             || ((tap_exp_p0 == NAR) && !bus.dut_inf)
             || ((tap_exp_p0 == '0)  && !bus.dut_zero);
   end

   // ---- stage p1: registered check result and run statistics ----
   // Check outputs and counters; a new run clears the statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         diff_p1     <= '0;
         mism_p1     <= 1'b0;
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
         proto_cnt_q <= '0;
         max_diff_q  <= '0;
      end else begin
         vld_p1 <= tap_vld_p0;
         if (tap_vld_p0) begin
            diff_p1 <= diff_p0;
            mism_p1 <= mism_p0;
         end
         if (run_clear) begin
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            proto_cnt_q <= '0;
            max_diff_q  <= '0;
         end else if (tap_vld_p0) begin
            vec_cnt_q <= sat_inc(vec_cnt_q);
            if (mism_p0)       err_cnt_q   <= sat_inc(err_cnt_q);
            if (!bus.dut_done) proto_cnt_q <= sat_inc(proto_cnt_q);
            if (diff_p0 > max_diff_q) max_diff_q <= diff_p0;
         end
      end
   end

   // Run-control state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Drain countdown: loaded when the issue stream stops, counts down while draining.
   always_ff @(posedge clk) begin
      if (reset) begin
         drain_cnt <= '0;
      end else if (state_q == S_RUN && !bus.start) begin
         drain_cnt <= DRAIN_LOAD;
      end else if (state_q == S_DRAIN && drain_cnt != '0) begin
         drain_cnt <= drain_cnt - 5'd1;
      end
   end

   // Next-state logic for the run sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_RUN;
         S_RUN:    if (!bus.start) state_d = S_DRAIN;
         S_DRAIN: begin
            if (bus.start)                                state_d = S_RUN;
            else if (drain_cnt == '0 && vld_line == '0)   state_d = S_REPORT;
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
      bus.report_valid = (state_q == S_REPORT);
      run_clear        = (state_q == S_IDLE) && bus.start;
   end

   assign bus.diff        = diff_p1;
   assign bus.diff_valid  = vld_p1;
   assign bus.mismatch    = mism_p1;
   assign bus.vec_count   = vec_cnt_q;
   assign bus.err_count   = err_cnt_q;
   assign bus.proto_count = proto_cnt_q;
   assign bus.max_diff    = max_diff_q;

endmodule

// File: tb/tb_posit_mult_checker.sv
// Bench for posit_mult_checker: a table of single-vector runs with fixed
// expectations, hand sequences for run continuation, protocol errors and
// mid-run reset, and randomized traffic against a run-level reference model.
module tb_posit_mult_checker;
   localparam int          N   = 32;
   localparam int          L   = 4;
   localparam logic [31:0] NAR = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   posit_mult_checker_if #(.N(N)) bus0 ();
   posit_mult_checker_if #(.N(N)) bus3 ();

   assign bus3.start      = bus0.start;
   assign bus3.exp_in     = bus0.exp_in;
   assign bus3.dut_result = bus0.dut_result;
   assign bus3.dut_inf    = bus0.dut_inf;
   assign bus3.dut_zero   = bus0.dut_zero;
   assign bus3.dut_done   = bus0.dut_done;

   posit_mult_checker #(.N(N), .ES(2), .LATENCY(L), .TOL(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
   posit_mult_checker #(.N(N), .ES(2), .LATENCY(L), .TOL(3)) dut3 (.clk(clk), .reset(rst), .bus(bus3));

   typedef struct { logic [31:0] r; bit inf; bit zero; bit done; bit v; } resp_t;
   typedef struct { bit v; logic [31:0] d; bit m0; bit m3; bit pe; } evt_t;
   typedef struct { logic [31:0] e; logic [31:0] r; bit inf; bit zero; bit done;
                    logic [31:0] d; bit m0; bit m3; } vec_t;

   resp_t resp_ring [32];
   evt_t  evt_ring  [32];
   bit    clr_ring  [32];
   vec_t  tbl       [12];

   int          cyc;
   int          n_chk;
   int          n_fail;
   int          n_rep;
   logic [31:0] m_vec, m_err0, m_err3, m_proto, m_max;
   bit          m_run;
   int          m_end;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, expv);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic expv);
      chk(nm, {31'b0, act}, {31'b0, expv});
   endtask

   function automatic logic [31:0] mag(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic bit bad(input logic [31:0] e, input logic [31:0] r,
                              input bit inf, input bit zero, input int tol);
      return (mag(e, r) > 32'(tol)) || (e == NAR && !inf) || (e == 32'h0 && !zero);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) begin
         resp_ring[i].v = 1'b0;
         evt_ring[i].v  = 1'b0;
         clr_ring[i]    = 1'b0;
      end
      m_vec = 0; m_err0 = 0; m_err3 = 0; m_proto = 0; m_max = 0;
      m_run = 1'b0;
      m_end = 0;
   endtask

   task automatic observe(input bit busy_e, input bit rep_e);
      int sl;
      evt_t ev;
      sl = cyc % 32;
      if (clr_ring[sl]) begin
         m_vec = 0; m_err0 = 0; m_err3 = 0; m_proto = 0; m_max = 0;
         clr_ring[sl] = 1'b0;
      end
      ev = evt_ring[sl];
      evt_ring[sl].v = 1'b0;
      if (ev.v) begin
         m_vec++;
         if (ev.m0) m_err0++;
         if (ev.m3) m_err3++;
         if (ev.pe) m_proto++;
         if (ev.d > m_max) m_max = ev.d;
      end
      chk1("busy", bus0.busy, busy_e);
      chk1("report_valid", bus0.report_valid, rep_e);
      chk1("diff_valid", bus0.diff_valid, ev.v);
      chk1("diff_valid_tol3", bus3.diff_valid, ev.v);
      if (ev.v) begin
         chk("diff", bus0.diff, ev.d);
         chk1("mismatch", bus0.mismatch, ev.m0);
         chk1("mismatch_tol3", bus3.mismatch, ev.m3);
      end
      chk("vec_count", bus0.vec_count, m_vec);
      chk("err_count", bus0.err_count, m_err0);
      chk("err_count_tol3", bus3.err_count, m_err3);
      chk("proto_count", bus0.proto_count, m_proto);
      chk("max_diff", bus0.max_diff, m_max);
      if (bus0.report_valid) n_rep++;
   endtask

   // One clock cycle with the given start/exp_in; multiplier outputs come from the response ring.
   task automatic tick(input bit s, input logic [31:0] e);
      int sl;
      bit busy_e, rep_e;
      sl     = cyc % 32;
      busy_e = m_run && (cyc <= m_end);
      rep_e  = m_run && (cyc == m_end + 1);
      if (rep_e) begin
         m_run = 1'b0;
      end else if (s) begin
         if (!m_run) begin
            m_run = 1'b1;
            clr_ring[(cyc + 1) % 32] = 1'b1;
         end
         m_end = cyc + L + 3;
      end
      bus0.start  = s;
      bus0.exp_in = e;
      if (resp_ring[sl].v) begin
         bus0.dut_result = resp_ring[sl].r;
         bus0.dut_inf    = resp_ring[sl].inf;
         bus0.dut_zero   = resp_ring[sl].zero;
         bus0.dut_done   = resp_ring[sl].done;
      end else begin
         bus0.dut_result = $urandom;
         bus0.dut_inf    = 1'($urandom);
         bus0.dut_zero   = 1'($urandom);
         bus0.dut_done   = 1'($urandom);
      end
      resp_ring[sl].v = 1'b0;
      @(negedge clk);
      observe(busy_e, rep_e);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input logic [31:0] e, input logic [31:0] r,
                        input bit inf, input bit zero, input bit done);
      int t4, t5;
      t4 = (cyc + L) % 32;
      t5 = (cyc + L + 1) % 32;
      resp_ring[t4].r    = r;
      resp_ring[t4].inf  = inf;
      resp_ring[t4].zero = zero;
      resp_ring[t4].done = done;
      resp_ring[t4].v    = 1'b1;
      evt_ring[t5].v     = 1'b1;
      evt_ring[t5].d     = mag(e, r);
      evt_ring[t5].m0    = bad(e, r, inf, zero, 0);
      evt_ring[t5].m3    = bad(e, r, inf, zero, 3);
      evt_ring[t5].pe    = !done;
      tick(1'b1, e);
   endtask

   task automatic issue_rand();
      logic [31:0] e, r;
      bit inf, zero, done;
      int kind;
      kind = $urandom_range(0, 9);
      e    = $urandom;
      r    = e + 32'($urandom_range(0, 8)) - 32'd4;
      inf  = 1'($urandom);
      zero = 1'($urandom);
      done = ($urandom_range(0, 19) != 0);
      if (kind == 0) begin
         e = NAR;
         r = ($urandom_range(0, 1) == 0) ? NAR : NAR + 32'($urandom_range(0, 5));
      end else if (kind == 1) begin
         e = 32'h0;
         r = 32'($urandom_range(0, 5));
      end
      issue(e, r, inf, zero, done);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64 && m_run; i++) tick(1'b0, $urandom);
      tick(1'b0, $urandom);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus0.start = 1'b0;
      @(posedge clk); #1; cyc++;
      @(posedge clk); #1; cyc++;
      rst = 1'b0;
      clear_model();
      chk1("rst_busy", bus0.busy, 1'b0);
      chk1("rst_report_valid", bus0.report_valid, 1'b0);
      chk1("rst_diff_valid", bus0.diff_valid, 1'b0);
      chk1("rst_mismatch", bus0.mismatch, 1'b0);
      chk("rst_diff", bus0.diff, 32'h0);
      chk("rst_vec_count", bus0.vec_count, 32'h0);
      chk("rst_err_count", bus0.err_count, 32'h0);
      chk("rst_proto_count", bus0.proto_count, 32'h0);
      chk("rst_max_diff", bus0.max_diff, 32'h0);
      chk("rst_err_count_tol3", bus3.err_count, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rep0;
      cyc = 0; n_chk = 0; n_fail = 0; n_rep = 0;
      bus0.start = 1'b0; bus0.exp_in = '0; bus0.dut_result = '0;
      bus0.dut_inf = 1'b0; bus0.dut_zero = 1'b0; bus0.dut_done = 1'b0;
      clear_model();
      do_reset();

      tbl[0]  = '{32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      tbl[1]  = '{32'h4000_0000, 32'h4000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
      tbl[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
      tbl[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
      tbl[6]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1};
      tbl[7]  = '{32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1, 1'b1};
      tbl[8]  = '{32'h4000_0004, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b1};
      tbl[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
      tbl[10] = '{32'h0000_0000, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
      tbl[11] = '{32'h3FFF_FFFF, 32'h4000_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b1, 1'b0};

      // Single-vector runs with fixed expectations, result read L+1 cycles after issue.
      for (int k = 0; k < 12; k++) begin
         rep0 = n_rep;
         issue(tbl[k].e, tbl[k].r, tbl[k].inf, tbl[k].zero, tbl[k].done);
         repeat (L) tick(1'b0, $urandom);
         chk1("tbl_diff_valid", bus0.diff_valid, 1'b1);
         chk("tbl_diff", bus0.diff, tbl[k].d);
         chk1("tbl_mismatch", bus0.mismatch, tbl[k].m0);
         chk1("tbl_mismatch_tol3", bus3.mismatch, tbl[k].m3);
         wait_idle();
         chk("tbl_vec_count", bus0.vec_count, 32'd1);
         chk("tbl_err_count", bus0.err_count, {31'b0, tbl[k].m0});
         chk("tbl_err_count_tol3", bus3.err_count, {31'b0, tbl[k].m3});
         chk("tbl_proto_count", bus0.proto_count, {31'b0, !tbl[k].done});
         chk("tbl_max_diff", bus0.max_diff, tbl[k].d);
         chk("tbl_reports", 32'(n_rep - rep0), 32'd1);
      end

      // 100 back-to-back vectors, two idle cycles, 50 more: one continuous run.
      rep0 = n_rep;
      repeat (100) issue_rand();
      repeat (2) tick(1'b0, $urandom);
      repeat (50) issue_rand();
      wait_idle();
      chk("cont_vec_count", bus0.vec_count, 32'd150);
      chk("cont_reports", 32'(n_rep - rep0), 32'd1);

      // Three checked cycles with dut_done low.
      for (int k = 0; k < 20; k++) begin
         logic [31:0] e;
         e = 32'h4000_0000 + 32'(k);
         issue(e, e, 1'b0, 1'b0, !(k == 3 || k == 7 || k == 12));
      end
      wait_idle();
      chk("proto_proto_count", bus0.proto_count, 32'd3);
      chk("proto_vec_count", bus0.vec_count, 32'd20);

      // Start presented in the report cycle must be ignored.
      rep0 = n_rep;
      issue(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 64 && !(m_run && cyc == m_end + 1); i++) tick(1'b0, $urandom);
      tick(1'b1, 32'h1234_5678);
      repeat (10) tick(1'b0, $urandom);
      chk1("rep_start_busy", bus0.busy, 1'b0);
      chk("rep_start_reports", 32'(n_rep - rep0), 32'd1);

      // Randomized runs with random gaps (short gaps drain and resume, long ones end the run).
      for (int run = 0; run < 8; run++) begin
         int len;
         len = $urandom_range(5, 40);
         for (int i = 0; i < len; i++) begin
            if (m_run && cyc == m_end + 1) tick(1'b1, $urandom);
            else if ($urandom_range(0, 3) != 0) issue_rand();
            else repeat ($urandom_range(1, 9)) tick(1'b0, $urandom);
         end
         wait_idle();
      end

      // Reset at run cycle 10 discards in-flight vectors without a report.
      rep0 = n_rep;
      for (int k = 0; k < 10; k++) issue_rand();
      do_reset();
      repeat (20) tick(1'b0, $urandom);
      chk("midreset_reports", 32'(n_rep - rep0), 32'd0);
      chk("midreset_vec_count", bus0.vec_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
